// File: rtl/cv32e40n_data_resp_mem.sv
// -----------------------------------------------------------------------------
// cv32e40n_data_resp_mem
//
// Word-organised scratchpad that answers the core/NVPE data request/grant/
// rvalid protocol. One request is accepted per cycle at most, and responses
// come back in order a fixed RESP_LATENCY cycles after the grant. The number
// of cycles a request waits for its grant is programmable so that masters'
// wait-state handling can be exercised.
//
// Handshake: a request is accepted on the rising edge that ends a cycle with
// data_req_i & data_gnt_o. Address, write enable, byte enables and write data
// are only looked at in that cycle. Every accepted request produces exactly one
// data_rvalid_o pulse RESP_LATENCY cycles later; there is no backpressure on
// the response side. data_rdata_o / data_err_o are 0 whenever data_rvalid_o
// is 0.
//
// Parameters:
//   ADDR_WIDTH   - byte-address bits decoded, depth = 2^(ADDR_WIDTH-2) words
//   GNT_STALL    - cycles a request waits for its grant (0..15)
//   RESP_LATENCY - cycles from grant to data_rvalid_o (1..8)
//   LFSR_SEED    - reset value of the random-stall LFSR (nonzero)
//
// Optional feature (define CV32E40N_DATA_RESP_MEM_RANDOM_STALL_EN):
//   the stall target for each request is taken from a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11) as LFSR[3:0] mod (GNT_STALL+1); the LFSR advances on
//   every accept. Without the macro the stall target is constant GNT_STALL.
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_ni        in   asynchronous active-low reset
//   data_req_i    in   request valid
//   data_gnt_o    out  request accepted this cycle (combinational)
//   data_addr_i   in   byte address, [1:0] ignored
//   data_we_i     in   1 = write, 0 = read
//   data_be_i     in   byte enables for writes
//   data_wdata_i  in   write data
//   data_rvalid_o out  response valid
//   data_rdata_o  out  read data (0 for writes and errors)
//   data_err_o    out  response error (out-of-range address)
// -----------------------------------------------------------------------------
module cv32e40n_data_resp_mem #(
   parameter int          ADDR_WIDTH   = 16,
   parameter int          GNT_STALL    = 0,
   parameter int          RESP_LATENCY = 1,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** IDX_W;

   // Elaboration-time parameter checks.
   if (RESP_LATENCY < 1 || RESP_LATENCY > 8) begin : g_bad_latency
      $error("RESP_LATENCY must be in 1..8");
   end
   if (GNT_STALL < 0 || GNT_STALL > 15) begin : g_bad_stall
      $error("GNT_STALL must be in 0..15");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end

   logic [3:0]       stall_cnt;
   logic [3:0]       stall_target;
   logic             accept;
   logic             in_range;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      rd_word;
   logic             unused_addr_lsb;

   logic [31:0] mem [DEPTH];

   logic [RESP_LATENCY-1:0] pipe_valid;
   logic [RESP_LATENCY-1:0] pipe_err;
   logic [31:0]             pipe_rdata [RESP_LATENCY];

   // Byte offset within the word has no meaning for a word memory.
   assign unused_addr_lsb = ^data_addr_i[1:0];

   // ---------------------------------------------------------------------------
   // Grant generation
   // ---------------------------------------------------------------------------
   // rst_ni is folded in so that no grant can be seen while reset is held,
   // even before the first clock edge clears the counter.
   assign data_gnt_o = data_req_i & (stall_cnt == stall_target) & rst_ni;
   assign accept     = data_req_i & data_gnt_o;

   // Counts consecutive waiting cycles of the current request; restarts after
   // every grant so back-to-back requests each wait the full target.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt <= '0;
      end else if (!data_req_i || data_gnt_o) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + 4'd1;
      end
   end

`ifdef CV32E40N_DATA_RESP_MEM_RANDOM_STALL_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr <= LFSR_SEED;
      end else if (accept) begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end

   // Target never exceeds GNT_STALL, so the counter always reaches it.
   assign stall_target = 4'({28'd0, lfsr[3:0]} % (GNT_STALL + 1));
`else
   assign stall_target = 4'(GNT_STALL);
`endif

   // ---------------------------------------------------------------------------
   // Memory array (contents are not reset)
   // ---------------------------------------------------------------------------
   assign in_range = (data_addr_i >> ADDR_WIDTH) == 32'd0;
   assign word_idx = data_addr_i[ADDR_WIDTH-1:2];
   assign rd_word  = mem[word_idx];

   always_ff @(posedge clk_i) begin
      if (accept && in_range && data_we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response pipeline
   // ---------------------------------------------------------------------------
   // Stage 0 holds the response captured at the accept edge; each stage carries
   // zero data when empty so the output needs no extra masking.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int s = 0; s < RESP_LATENCY; s++) begin
            pipe_rdata[s] <= '0;
         end
      end else begin
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept & ~in_range;
         pipe_rdata[0] <= (accept && in_range && !data_we_i) ? rd_word : 32'd0;
         for (int s = 1; s < RESP_LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_err[s]   <= pipe_err[s-1];
            pipe_rdata[s] <= pipe_rdata[s-1];
         end
      end
   end

   assign data_rvalid_o = pipe_valid[RESP_LATENCY-1];
   assign data_err_o    = pipe_err[RESP_LATENCY-1];
   assign data_rdata_o  = pipe_rdata[RESP_LATENCY-1];

endmodule

// File: doc/cv32e40n_data_resp_mem.md
# cv32e40n_data_resp_mem

Word-organised data-bus responder (slave) for the core/NVPE data request/grant/rvalid protocol, placed on the slave port of the data crossbar as a scratchpad or in place of the RAM data port. Accepts at most one request per cycle and returns in-order responses after a fixed, parameterised latency. Programmable grant stalling lets benches exercise both masters' wait-state handling.

## Interface
- ADDR_WIDTH, 16: byte-address bits decoded; depth = 2^(ADDR_WIDTH-2) 32-bit words.
- GNT_STALL, 0: cycles `data_req_i` must be high before `data_gnt_o` asserts (0..15).
- RESP_LATENCY, 1: cycles from grant to `data_rvalid_o` (1..8; 0 is an elaboration error).
- LFSR_SEED, 16'hACE1: seed for the random-stall LFSR; nonzero.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  request valid.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address; [1:0] ignored.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables for writes.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  32  read data; 0 for write and error responses.
- data_err_o  out  1  response error flag, qualified by `data_rvalid_o`.

## Operation
- Reset state: `data_gnt_o`=0, `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, stall counter 0, response pipeline empty. Memory contents are not reset.
- Stall counter:
  - Increments each cycle `data_req_i`=1 and `data_gnt_o`=0.
  - Clears on grant or when `data_req_i`=0.
- Grant is combinational: `data_gnt_o` = `data_req_i` & (stall counter == stall target) & `rst_ni`. The stall target is GNT_STALL.
- A request is accepted on a cycle with `data_req_i` & `data_gnt_o`.
- In-range access (`data_addr_i`[31:ADDR_WIDTH] == 0):
  - Write: updates bytes with `data_be_i`=1 at the accept edge.
  - Read: samples the word at the accept edge.
- Out-of-range access:
  - No memory effect.
  - Response has `data_err_o`=1 and `data_rdata_o`=0.
- Response pipeline:
  - RESP_LATENCY-stage shift register of {valid, err, rdata}. Stage 0 is loaded on accept and shifts every cycle.
  - Up to RESP_LATENCY responses are outstanding. There is no backpressure.
  - Responses leave in accept order.
- Read-after-write to the same word on the next accept returns the new data.
- Reset mid-operation drops all pending responses; none appear after `rst_ni` rises.
- Address, write enable, byte enables and write data are sampled only on accept. Changing them while `data_gnt_o`=0 is legal and has no effect.

## Timing
- GNT_STALL=0: grant in the same cycle as the request. Back-to-back accepts occur every cycle.
- GNT_STALL=N: with `data_req_i` held high from cycle c, grant occurs in cycle c+N. After each accept the counter restarts, so consecutive requests are accepted every N+1 cycles.
- Request accepted in cycle n → `data_rvalid_o` high in cycle n+RESP_LATENCY for exactly one cycle, with `data_rdata_o` and `data_err_o` valid in the same cycle.
- `data_rdata_o` and `data_err_o` read 0 in cycles with `data_rvalid_o`=0.

## Configuration
- Macro: CV32E40N_DATA_RESP_MEM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; loaded with LFSR_SEED at reset) advances on every accept.
  - The stall target for the next request is LFSR[3:0] mod (GNT_STALL+1).
  - Latency and ordering are unchanged.
- Undefined: no LFSR is present; the stall target is constant GNT_STALL.

## Test plan
- Reset: hold `rst_ni`=0 with `data_req_i`=1 → `data_gnt_o`, `data_rvalid_o`, `data_rdata_o` and `data_err_o` all 0.
- Basic access (GNT_STALL=0, RESP_LATENCY=1):
  - Write 0xDEADBEEF to 0x10 with be=4'hF → granted the same cycle; rvalid the next cycle with rdata 0 and err 0.
  - Then read 0x10 → rdata 0xDEADBEEF.
- Byte enables: write 0x11223344 with be=4'b0101 over 0xDEADBEEF, then read → 0xDE22BE44.
- Stall (GNT_STALL=3, macro undefined): hold req high from cycle c → gnt only in cycle c+3. A second held request is granted at c+7.
- Pipelined reads (RESP_LATENCY=3): reads of 0x0, 0x4, 0x8 accepted in cycles n, n+1, n+2 → rvalid in n+3, n+4, n+5 with data in order.
- Error and reset:
  - ADDR_WIDTH=16: read 0x0001_0000 → err 1, rdata 0. Write 0x0001_0000 → err 1 and no memory change.
  - With 2 responses pending, pulse `rst_ni` low → no rvalid after reset.
